// File: rtl/ddi_phase_scheduler.sv
// Dwell timer and phase arbiter for the single-DDI light FSM.
// Counts ticks per FSM state and picks the next green at each ALL_RED entry.
module ddi_phase_scheduler #(
  parameter int CNT_W            = 8,
  parameter int RED_TICKS        = 2,
  parameter int GREEN_TICKS      = 20,
  parameter int YELLOW_TICKS     = 4,
  parameter int PRIO_GREEN_TICKS = 10,
  parameter int MAX_PRIO_RUN     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [3:0] fsm_state,
  input  logic       east_req,
  input  logic       west_req,
  output logic       timing_done,
  output logic [1:0] phase,
  output logic       sync,
  output logic       east_pend,
  output logic       west_pend
);

  localparam logic [3:0] S_ALL_RED = 4'd0;
  localparam logic [3:0] S_P1G     = 4'd1;
  localparam logic [3:0] S_P1Y     = 4'd2;
  localparam logic [3:0] S_P2G     = 4'd3;
  localparam logic [3:0] S_P2Y     = 4'd4;
  localparam logic [3:0] S_EG      = 4'd5;
  localparam logic [3:0] S_EY      = 4'd6;
  localparam logic [3:0] S_WG      = 4'd7;
  localparam logic [3:0] S_WY      = 4'd8;

  localparam logic [1:0] PH_1    = 2'b00;
  localparam logic [1:0] PH_2    = 2'b01;
  localparam logic [1:0] PH_PRIO = 2'b10;

  localparam int PR_W = $clog2(MAX_PRIO_RUN + 2);
  localparam logic [PR_W-1:0] PR_MAX = PR_W'(MAX_PRIO_RUN);

  localparam logic [CNT_W-1:0] RED_M1 = CNT_W'(RED_TICKS - 1);
  localparam logic [CNT_W-1:0] GRN_M1 = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YEL_M1 = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] PRI_M1 = CNT_W'(PRIO_GREEN_TICKS - 1);

  logic [3:0]       prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sent_q, sent_d;
  logic             done_q, done_d;
  logic [1:0]       phase_q, phase_d;
  logic             sync_q, sync_d;
  logic             epend_q, epend_d;
  logic             wpend_q, wpend_d;
  logic             nnorm_q, nnorm_d;
  logic             nprio_q, nprio_d;
  logic [PR_W-1:0]  run_q, run_d;

  logic             evt;
  logic             has_dwell;
  logic [CNT_W-1:0] dwell_m1;

  assign evt = (fsm_state != prev_q);

  // MAINT and undefined encodings carry no dwell: counter frozen
  always_comb begin
    has_dwell = 1'b1;
    dwell_m1  = '0;
    case (fsm_state)
      S_ALL_RED:                 dwell_m1 = RED_M1;
      S_P1G, S_P2G:              dwell_m1 = GRN_M1;
      S_EG, S_WG:                dwell_m1 = PRI_M1;
      S_P1Y, S_P2Y, S_EY, S_WY:  dwell_m1 = YEL_M1;
      default:                   has_dwell = 1'b0;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    sent_d  = sent_q;
    done_d  = 1'b0;
    phase_d = phase_q;
    sync_d  = sync_q;
    nnorm_d = nnorm_q;
    nprio_d = nprio_q;
    run_d   = run_q;
    epend_d = epend_q | east_req;
    wpend_d = wpend_q | west_req;

    if (evt) begin
      cnt_d  = '0;
      sent_d = 1'b0;
    end else if (has_dwell && !sent_q && tick) begin
      if (cnt_q == dwell_m1) begin
        done_d = 1'b1;
        sent_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (evt) begin
      unique case (1'b1)
        fsm_state == S_ALL_RED: begin
          if ((epend_q || wpend_q) && run_q < PR_MAX) begin
            phase_d = PH_PRIO;
            sync_d  = (epend_q && wpend_q) ? nprio_q : wpend_q;
          end else begin
            phase_d = nnorm_q ? PH_2 : PH_1;
          end
        end
        fsm_state == S_P1G: begin
          nnorm_d = 1'b1;
          run_d   = '0;
        end
        fsm_state == S_P2G: begin
          nnorm_d = 1'b0;
          run_d   = '0;
        end
        fsm_state == S_EG: begin
          nprio_d = 1'b1;
          epend_d = 1'b0;
          run_d   = (run_q == PR_MAX) ? run_q : run_q + 1'b1;
        end
        fsm_state == S_WG: begin
          nprio_d = 1'b0;
          wpend_d = 1'b0;
          run_d   = (run_q == PR_MAX) ? run_q : run_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= S_ALL_RED;
      cnt_q   <= '0;
      sent_q  <= 1'b0;
      done_q  <= 1'b0;
      phase_q <= PH_1;
      sync_q  <= 1'b0;
      epend_q <= 1'b0;
      wpend_q <= 1'b0;
      nnorm_q <= 1'b0;
      nprio_q <= 1'b0;
      run_q   <= '0;
    end else begin
      prev_q  <= fsm_state;
      cnt_q   <= cnt_d;
      sent_q  <= sent_d;
      done_q  <= done_d;
      phase_q <= phase_d;
      sync_q  <= sync_d;
      epend_q <= epend_d;
      wpend_q <= wpend_d;
      nnorm_q <= nnorm_d;
      nprio_q <= nprio_d;
      run_q   <= run_d;
    end
  end

  assign timing_done = done_q;
  assign phase       = phase_q;
  assign sync        = sync_q;
  assign east_pend   = epend_q;
  assign west_pend   = wpend_q;

endmodule

// File: tb/tb_ddi_phase_scheduler.sv
// Bench for ddi_phase_scheduler: looped-back light FSM plus
// a tick-counting reference model, directed scenarios then random traffic.
module tb_ddi_phase_scheduler;

  localparam int RED  = 1;
  localparam int GRN  = 3;
  localparam int YEL  = 2;
  localparam int PRI  = 2;
  localparam int MAXR = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] fsm_state = 4'd0;
  logic       east_req = 1'b0;
  logic       west_req = 1'b0;
  logic       timing_done;
  logic [1:0] phase;
  logic       sync;
  logic       east_pend;
  logic       west_pend;

  always #5 clk = ~clk;

  ddi_phase_scheduler #(
    .CNT_W(8),
    .RED_TICKS(RED),
    .GREEN_TICKS(GRN),
    .YELLOW_TICKS(YEL),
    .PRIO_GREEN_TICKS(PRI),
    .MAX_PRIO_RUN(MAXR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tick(tick),
    .fsm_state(fsm_state),
    .east_req(east_req),
    .west_req(west_req),
    .timing_done(timing_done),
    .phase(phase),
    .sync(sync),
    .east_pend(east_pend),
    .west_pend(west_pend)
  );

  int n_chk = 0;
  int n_pass = 0;

  int m_prev, m_ticks, m_phase, m_nnorm, m_nprio, m_run, m_fsm;
  bit m_sent, m_done, m_epend, m_wpend, m_sync, loop_en;
  int dut_pulses = 0;
  int mdl_pulses = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, obs, exp);
  endtask

  function automatic int dwell_of(int s);
    case (s)
      0:          return RED;
      1, 3:       return GRN;
      5, 7:       return PRI;
      2, 4, 6, 8: return YEL;
      default:    return 0;
    endcase
  endfunction

  function automatic int fsm_next(int s, int ph, bit sy);
    case (s)
      0: begin
        if (ph == 0) return 1;
        if (ph == 1) return 3;
        return sy ? 7 : 5;
      end
      1: return 2;
      3: return 4;
      5: return 6;
      7: return 8;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_prev  = 0;
    m_ticks = 0;
    m_sent  = 0;
    m_done  = 0;
    m_epend = 0;
    m_wpend = 0;
    m_phase = 0;
    m_sync  = 0;
    m_nnorm = 0;
    m_nprio = 0;
    m_run   = 0;
  endtask

  task automatic model_update();
    int st;
    bit ev, pe, pw;
    if (!rst_n) begin
      model_reset();
    end else begin
      st = int'(fsm_state);
      ev = (st != m_prev);
      m_done = 0;
      if (ev) begin
        m_ticks = 0;
        m_sent  = 0;
      end else if (dwell_of(st) > 0 && !m_sent && tick) begin
        m_ticks++;
        if (m_ticks == dwell_of(st)) begin
          m_done = 1;
          m_sent = 1;
        end
      end
      pe = m_epend;
      pw = m_wpend;
      if (ev && st == 0) begin
        if ((pe || pw) && m_run < MAXR) begin
          m_phase = 2;
          m_sync  = (pe && pw) ? m_nprio[0] : pw;
        end else begin
          m_phase = m_nnorm;
        end
      end
      if (ev) begin
        case (st)
          1: begin m_nnorm = 1; m_run = 0; end
          3: begin m_nnorm = 0; m_run = 0; end
          5: begin m_nprio = 1; if (m_run < MAXR) m_run++; end
          7: begin m_nprio = 0; if (m_run < MAXR) m_run++; end
          default: ;
        endcase
      end
      m_epend = (pe || east_req) && !(ev && st == 5);
      m_wpend = (pw || west_req) && !(ev && st == 7);
      m_prev = st;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("done", timing_done, m_done);
    check("phase", phase, m_phase);
    check("sync", sync, m_sync);
    check("east_pend", east_pend, m_epend);
    check("west_pend", west_pend, m_wpend);
    if (timing_done) dut_pulses++;
    if (m_done) mdl_pulses++;
    if (loop_en && m_done) m_fsm = fsm_next(m_fsm, m_phase, m_sync);
    if (loop_en) fsm_state = 4'(m_fsm);
  endtask

  task automatic wait_fsm(int target, string tag);
    bit ok;
    ok = (m_fsm == target);
    for (int i = 0; i < 200 && !ok; i++) begin
      step();
      ok = (m_fsm == target);
    end
    check(tag, ok, 1);
  endtask

  task automatic wait_red_entry(string tag);
    bit ok;
    ok = (m_fsm != 0);
    for (int i = 0; i < 200 && !ok; i++) begin
      step();
      ok = (m_fsm != 0);
    end
    check({tag, "_leave"}, ok, 1);
    wait_fsm(0, tag);
    step();
  endtask

  initial begin
    int base, n;
    bit ok;
    int exp_ph[4];
    int exp_sy[4];
    exp_ph = '{2, 2, 0, 2};
    exp_sy = '{0, 1, 0, 0};

    loop_en = 0;
    model_reset();
    m_fsm = 0;
    #12;
    check("rst_done", timing_done, 0);
    check("rst_phase", phase, 0);
    check("rst_sync", sync, 0);
    check("rst_epend", east_pend, 0);
    check("rst_wpend", west_pend, 0);
    rst_n = 1'b1;
    step();

    // Plain rotation, tick every cycle
    loop_en = 1;
    tick = 1'b1;
    repeat (40) step();
    check("t1_pulses", dut_pulses, mdl_pulses);

    // Single eastbound request
    wait_fsm(1, "t2_reach_p1g");
    east_req = 1'b1;
    step();
    east_req = 1'b0;
    check("t2_epend_set", east_pend, 1);
    wait_red_entry("t2_red");
    check("t2_phase", phase, 2);
    check("t2_sync", sync, 0);
    wait_fsm(5, "t2_reach_eg");
    step();
    check("t2_epend_clr", east_pend, 0);
    n = 0;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      step();
      n++;
      ok = timing_done;
    end
    check("t2_eg_dwell", n, PRI);

    // Both sides held: starvation guard
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    loop_en = 0;
    east_req = 1'b1;
    west_req = 1'b1;
    fsm_state = 4'd9;
    step();
    fsm_state = 4'd0;
    m_fsm = 0;
    loop_en = 1;
    step();
    check("t3_sel0_phase", phase, exp_ph[0]);
    check("t3_sel0_sync", sync, exp_sy[0]);
    for (int k = 1; k < 4; k++) begin
      wait_red_entry("t3_red");
      check($sformatf("t3_sel%0d_phase", k), phase, exp_ph[k]);
      if (exp_ph[k] == 2)
        check($sformatf("t3_sel%0d_sync", k), sync, exp_sy[k]);
    end
    east_req = 1'b0;
    west_req = 1'b0;

    // Tick starvation and FSM stall after done
    loop_en = 0;
    fsm_state = 4'd5;
    step();
    fsm_state = 4'd7;
    step();
    fsm_state = 4'd0;
    step();
    fsm_state = 4'd1;
    step();
    tick = 1'b0;
    base = dut_pulses;
    repeat (50) step();
    check("t4_no_tick", dut_pulses - base, 0);
    tick = 1'b1;
    repeat (10) step();
    check("t4_one_pulse", dut_pulses - base, 1);

    // Maintenance hold with a westbound request
    fsm_state = 4'd9;
    west_req = 1'b1;
    step();
    west_req = 1'b0;
    base = dut_pulses;
    repeat (10) step();
    check("t5_maint_quiet", dut_pulses - base, 0);
    check("t5_wpend_kept", west_pend, 1);
    fsm_state = 4'd0;
    m_fsm = 0;
    loop_en = 1;
    step();
    check("t5_phase", phase, 2);
    check("t5_sync", sync, 1);
    step();
    check("t5_red_done", timing_done, 1);

    // Asynchronous reset in the middle of a green dwell
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      step();
      ok = (m_prev == 3 && m_ticks == 2 && !m_sent);
    end
    check("t6_reach", ok, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_done", timing_done, 0);
    check("t6_rst_phase", phase, 0);
    check("t6_rst_sync", sync, 0);
    check("t6_rst_epend", east_pend, 0);
    check("t6_rst_wpend", west_pend, 0);
    model_reset();
    step();
    m_fsm = 0;
    fsm_state = 4'd0;
    rst_n = 1'b1;
    step();
    check("t6_first_done", timing_done, 1);
    check("t6_first_phase", phase, 0);

    // Random traffic
    base = dut_pulses;
    n = mdl_pulses;
    for (int i = 0; i < 1500; i++) begin
      tick = 1'($urandom_range(0, 1));
      east_req = ($urandom_range(0, 9) == 0);
      west_req = ($urandom_range(0, 9) == 0);
      step();
    end
    check("t7_pulses", dut_pulses - base, mdl_pulses - n);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
